// File: rtl/c4_pkg.sv
// Shared types and helpers for the grid drop engine: FSM states, default
// board geometry and the row-major cell index used by both board maps.
package c4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FALL,
    PLACE
  } state_t;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;

  // Row 0 is the bottom row; cells are laid out row by row.
  function automatic int cell_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/grid_drop_engine_if.sv
// Bundle of the engine's control inputs and status outputs, so a driver can
// hand the whole player-facing port set around as one object.
interface grid_drop_engine_if
  import c4_pkg::*;
#(
  parameter int  ROWS = DEF_ROWS,
  parameter int  COLS = DEF_COLS,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS + 1)
);

  logic                   new_game;
  logic                   play_en;
  logic                   drop_req;
  logic [COLS-1:0]        in_column;
  logic [CW-1:0]          column_decode;
  logic [ROWS*COLS-1:0]   out_gameboard;
  logic [ROWS*COLS-1:0]   out_players_cells;
  logic                   player_turn;
  logic                   busy;
  logic                   fall_active;
  logic [RW-1:0]          fall_row;
  logic                   invalid_column;
  logic                   drop_done;
  logic                   board_full;

  modport master (
    output new_game, play_en, drop_req, in_column,
    input  column_decode, out_gameboard, out_players_cells, player_turn,
           busy, fall_active, fall_row, invalid_column, drop_done, board_full
  );

  modport slave (
    input  new_game, play_en, drop_req, in_column,
    output column_decode, out_gameboard, out_players_cells, player_turn,
           busy, fall_active, fall_row, invalid_column, drop_done, board_full
  );

endinterface

// File: rtl/onehot_col_decoder.sv
// Turns a one-hot column select into a column index and flags whether the
// select really has exactly one bit set.
module onehot_col_decoder #(
  parameter int  COLS = 7,
  localparam int CW   = $clog2(COLS)
) (
  input  logic [COLS-1:0] col_vec,
  output logic [CW-1:0]   col_index,
  output logic            col_valid
);

  localparam logic [COLS-1:0] ONE = COLS'(1);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    col_index = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (col_vec[i]) begin
        col_index = CW'(i);
      end
    end
  end

  assign col_valid = (col_vec != '0) && ((col_vec & (col_vec - ONE)) == '0);

endmodule

// File: rtl/grid_drop_engine.sv
// Gravity-drop board engine: accepts a column request, animates the piece
// falling one row per cycle and commits it on top of the column stack.
module grid_drop_engine
  import c4_pkg::*;
#(
  parameter int  ROWS = DEF_ROWS,
  parameter int  COLS = DEF_COLS,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 play_en,
  input  logic                 drop_req,
  input  logic [COLS-1:0]      in_column,
  output logic [CW-1:0]        column_decode,
  output logic [ROWS*COLS-1:0] out_gameboard,
  output logic [ROWS*COLS-1:0] out_players_cells,
  output logic                 player_turn,
  output logic                 busy,
  output logic                 fall_active,
  output logic [RW-1:0]        fall_row,
  output logic                 invalid_column,
  output logic                 drop_done,
  output logic                 board_full
);

  localparam int            N       = ROWS * COLS;
  localparam logic [RW-1:0] ROWS_V  = RW'(ROWS);
  localparam logic [RW-1:0] TOP_ROW = RW'(ROWS - 1);
  localparam logic [RW-1:0] ONE_H   = RW'(1);

  state_t          state;
  state_t          state_next;
  logic [COLS-1:0] col_vec;
  logic [CW-1:0]   col_idx;
  logic            col_ok;
  logic            in_valid;
  logic [RW-1:0]   heights [COLS];
  logic [RW-1:0]   col_height;
  logic [COLS-1:0] col_full_after;
  logic [N-1:0]    place_mask;
  logic            accept;
  logic            clear_game;
  logic            reject;

  onehot_col_decoder #(.COLS(COLS)) u_decode (
    .col_vec   (in_column),
    .col_index (column_decode),
    .col_valid (in_valid)
  );

  // new_game takes priority over a same-cycle drop request.
  assign clear_game = (state == IDLE) && new_game;
  assign accept     = (state == IDLE) && drop_req && play_en && !new_game;
  assign col_height = heights[col_idx];
  assign reject     = !col_ok || (col_height == ROWS_V);
  assign place_mask = N'(col_vec) << cell_index(int'(col_height), 0, COLS);
  assign busy        = (state != IDLE);
  assign fall_active = (state == FALL);

  // Fullness as it will look once the pending piece is committed.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_full
    assign col_full_after[gi] = (heights[gi] == ROWS_V) ||
                                (col_vec[gi] && (col_height == TOP_ROW));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CHECK;
      CHECK:   state_next = reject ? IDLE : FALL;
      FALL:    if (fall_row <= col_height) state_next = PLACE;
      PLACE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_vec           <= '0;
      col_idx           <= '0;
      col_ok            <= 1'b0;
      fall_row          <= '0;
      out_gameboard     <= '0;
      out_players_cells <= '0;
      player_turn       <= 1'b0;
      invalid_column    <= 1'b0;
      drop_done         <= 1'b0;
      board_full        <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        heights[c] <= '0;
      end
    end else begin
      invalid_column <= 1'b0;
      drop_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_game) begin
            out_gameboard     <= '0;
            out_players_cells <= '0;
            player_turn       <= 1'b0;
            board_full        <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
              heights[c] <= '0;
            end
          end else if (accept) begin
            col_vec <= in_column;
            col_idx <= column_decode;
            col_ok  <= in_valid;
          end
        end
        CHECK: begin
          if (reject) begin
            invalid_column <= 1'b1;
          end else begin
            fall_row <= TOP_ROW;
          end
        end
        FALL: begin
          if (fall_row > col_height) begin
            fall_row <= fall_row - ONE_H;
          end
        end
        PLACE: begin
          out_gameboard <= out_gameboard | place_mask;
          if (player_turn) begin
            out_players_cells <= out_players_cells | place_mask;
          end
          if (col_height != ROWS_V) begin
            heights[col_idx] <= col_height + ONE_H;
          end
          player_turn <= ~player_turn;
          drop_done   <= 1'b1;
          board_full  <= &col_full_after;
        end
        default: ;
      endcase
    end
  end

endmodule
